// File: rtl/imem_sync.sv
// imem_sync: clocked instruction memory with a 1-cycle registered fetch,
// misalign/range fault flagging, a runtime program-load port and a post-reset clear.
module imem_sync #(
  parameter int N   = 32,
  parameter int AW  = 6,
  parameter int PCW = 64
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_fetch_req,
  input  logic [PCW-1:0] i_fetch_addr,
  output logic           o_fetch_ready,
  output logic           o_fetch_valid,
  output logic [N-1:0]   o_fetch_data,
  output logic           o_fetch_fault,
  input  logic           i_load_start,
  input  logic           i_load_we,
  input  logic [N-1:0]   i_load_data,
  input  logic           i_load_last,
  output logic           o_load_busy,
  output logic [AW:0]    o_load_count
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_LAST = {1'b0, {AW{1'b1}}};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t        r_state;
  logic [AW:0]   r_ptr;
  logic [AW:0]   r_load_count;
  logic          r_fetch_ready;
  logic          r_load_busy;
  logic          r_fetch_valid;
  logic          r_fetch_fault;
  logic [N-1:0]  r_fetch_data;
  logic [N-1:0]  r_mem [0:DEPTH-1];

  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [N-1:0]  w_wdata;
  logic          w_in_range;
  logic          w_accept;
  logic          w_fault;
  logic [AW-1:0] w_ridx;

  // The pointer is one bit wider than the index so that "full" is representable.
  assign w_in_range = ~r_ptr[AW];
  assign w_accept   = i_fetch_req & r_fetch_ready;
  assign w_ridx     = i_fetch_addr[AW+1:2];
  assign w_fault    = (|i_fetch_addr[1:0]) | (|i_fetch_addr[PCW-1:AW+2]);

  // Control FSM: clear sweep, run, and pointer-driven program load.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_CLEAR;
      r_ptr         <= {(AW+1){1'b0}};
      r_load_count  <= {(AW+1){1'b0}};
      r_fetch_ready <= 1'b0;
      r_load_busy   <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_ptr <= r_ptr + PTR_ONE;
          if (r_ptr == PTR_LAST) begin
            r_state       <= ST_RUN;
            r_fetch_ready <= 1'b1;
            r_load_busy   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (i_load_start) begin
            r_state       <= ST_LOAD;
            r_ptr         <= {(AW+1){1'b0}};
            r_load_count  <= {(AW+1){1'b0}};
            r_fetch_ready <= 1'b0;
            r_load_busy   <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (i_load_we) begin
            if (w_in_range) begin
              r_ptr        <= r_ptr + PTR_ONE;
              r_load_count <= r_load_count + PTR_ONE;
            end
            if (i_load_last) begin
              r_state       <= ST_RUN;
              r_fetch_ready <= 1'b1;
              r_load_busy   <= 1'b0;
            end
          end
        end
        default: begin
          r_state       <= ST_CLEAR;
          r_ptr         <= {(AW+1){1'b0}};
          r_fetch_ready <= 1'b0;
          r_load_busy   <= 1'b1;
        end
      endcase
    end
  end

  // Single write port shared by the clear sweep and the load stream.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_ptr[AW-1:0];
    w_wdata = {N{1'b0}};
    case (r_state)
      ST_CLEAR: w_we = ~i_reset;
      ST_LOAD: begin
        w_we    = ~i_reset & i_load_we & w_in_range;
        w_wdata = i_load_data;
      end
      default: w_we = 1'b0;
    endcase
  end

  // Memory array write.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Registered fetch port; data holds between fetches, faults return zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_fetch_data  <= {N{1'b0}};
    end else begin
      r_fetch_valid <= w_accept;
      r_fetch_fault <= w_accept & w_fault;
      if (w_accept) begin
        r_fetch_data <= w_fault ? {N{1'b0}} : r_mem[w_ridx];
      end
    end
  end

  assign o_fetch_ready = r_fetch_ready;
  assign o_load_busy   = r_load_busy;
  assign o_load_count  = r_load_count;
  assign o_fetch_valid = r_fetch_valid;
  assign o_fetch_fault = r_fetch_fault;
  assign o_fetch_data  = r_fetch_data;
endmodule

// File: tb/tb_imem_sync.sv
// Scoreboard bench for imem_sync: fetch expectations are queued when a fetch is
// driven and popped by a negedge monitor when fetch_valid appears.
module tb_imem_sync;
  localparam int N = 32;
  localparam int AW = 6;
  localparam int PCW = 64;
  localparam int DEPTH = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           fetch_req = 1'b0;
  logic [PCW-1:0] fetch_addr = '0;
  logic           load_start = 1'b0;
  logic           load_we = 1'b0;
  logic [N-1:0]   load_data = '0;
  logic           load_last = 1'b0;
  logic           fetch_ready;
  logic           fetch_valid;
  logic [N-1:0]   fetch_data;
  logic           fetch_fault;
  logic           load_busy;
  logic [AW:0]    load_count;

  logic [N-1:0] model [DEPTH];
  logic [N-1:0] load_buf [128];
  logic [N:0]   exp_q [$];
  logic [N:0]   mon_e;
  int checks = 0;
  int errors = 0;

  imem_sync #(.N(N), .AW(AW), .PCW(PCW)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
    .o_fetch_ready(fetch_ready), .o_fetch_valid(fetch_valid),
    .o_fetch_data(fetch_data), .o_fetch_fault(fetch_fault),
    .i_load_start(load_start), .i_load_we(load_we), .i_load_data(load_data),
    .i_load_last(load_last), .o_load_busy(load_busy), .o_load_count(load_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N:0] expect_fetch(input logic [PCW-1:0] a);
    logic f;
    f = (a[1:0] != 2'b00) || (a[PCW-1:AW+2] != '0);
    return f ? {1'b1, {N{1'b0}}} : {1'b0, model[a[AW+1:2]]};
  endfunction

  task automatic fetch(input logic [PCW-1:0] a);
    fetch_req = 1'b1;
    fetch_addr = a;
    exp_q.push_back(expect_fetch(a));
    cyc();
    fetch_req = 1'b0;
  endtask

  // Scoreboard consumer: every valid pops one expectation.
  always @(negedge clk) begin
    checks++;
    if (fetch_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: data=%h fault=%b with no fetch pending", fetch_data, fetch_fault);
      end else begin
        mon_e = exp_q.pop_front();
        if ({fetch_fault, fetch_data} !== mon_e) begin
          errors++;
          $display("FAIL fetch_result: got fault=%b data=%h, want fault=%b data=%h",
                   fetch_fault, fetch_data, mon_e[N], mon_e[N-1:0]);
        end
      end
    end else if (fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL idle_fault: fault=%b, want 0 when not valid", fetch_fault);
    end
  end

  task automatic wait_clear(input string tag);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (fetch_ready !== 1'b1 && n < 200) begin
      if (load_busy !== 1'b1) bad++;
      cyc();
      n++;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL %s_clear_len: ready after %0d cycles, want 64", tag, n);
    end
    checks++;
    if (bad != 0 || load_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_clear_busy: busy_low_cycles=%0d busy_end=%b, want 0 and 0", tag, bad, load_busy);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic do_load(input int n);
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    checks++;
    if (load_busy !== 1'b1 || fetch_ready !== 1'b0 || load_count !== 7'd0) begin
      errors++;
      $display("FAIL load_enter: busy=%b ready=%b count=%0d, want 1 0 0", load_busy, fetch_ready, load_count);
    end
    load_last = 1'b1;
    cyc();
    load_last = 1'b0;
    checks++;
    if (load_busy !== 1'b1 || load_count !== 7'd0) begin
      errors++;
      $display("FAIL last_without_we: busy=%b count=%0d, want 1 0", load_busy, load_count);
    end
    for (int k = 0; k < n; k++) begin
      load_we = 1'b1;
      load_data = load_buf[k];
      load_last = (k == n - 1);
      if (k < DEPTH) model[k] = load_buf[k];
      cyc();
    end
    load_we = 1'b0;
    load_last = 1'b0;
    checks++;
    if (fetch_ready !== 1'b1 || load_busy !== 1'b0) begin
      errors++;
      $display("FAIL load_exit: ready=%b busy=%b, want 1 0", fetch_ready, load_busy);
    end
    checks++;
    if (load_count !== 7'((n > DEPTH) ? DEPTH : n)) begin
      errors++;
      $display("FAIL load_count: got %0d, want %0d", load_count, (n > DEPTH) ? DEPTH : n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    checks++;
    if (fetch_valid !== 1'b0 || fetch_data !== 32'd0 || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_fetch_out: valid=%b data=%h fault=%b, want 0 0 0", fetch_valid, fetch_data, fetch_fault);
    end
    checks++;
    if (fetch_ready !== 1'b0 || load_busy !== 1'b1 || load_count !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl_out: ready=%b busy=%b count=%0d, want 0 1 0", fetch_ready, load_busy, load_count);
    end
    reset = 1'b0;
    wait_clear("reset");
    fetch(64'h0);
  endtask

  task automatic test_load();
    load_buf[0] = 32'hf800_0000;
    load_buf[1] = 32'hf800_8001;
    load_buf[2] = 32'hd61f_0300;
    do_load(3);
    fetch(64'h8);
    fetch(64'hC);
    fetch(64'h0);
  endtask

  task automatic test_fault();
    fetch(64'h6);
    fetch(64'h100);
    fetch(64'hFC);
    fetch(64'h8000_0000_0000_0004);
    fetch(64'h1);
  endtask

  task automatic test_back_to_back();
    int nv;
    nv = 0;
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 64'(i * 4);
      exp_q.push_back(expect_fetch(fetch_addr));
      cyc();
      if (fetch_valid === 1'b1) nv++;
    end
    fetch_req = 1'b0;
    checks++;
    if (nv != 3) begin
      errors++;
      $display("FAIL b2b_valid_run: %0d consecutive valid cycles, want 3", nv);
    end
    cyc();
    checks++;
    if (fetch_valid !== 1'b0 || fetch_data !== model[2]) begin
      errors++;
      $display("FAIL b2b_hold: valid=%b data=%h, want 0 %h", fetch_valid, fetch_data, model[2]);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 70; k++) load_buf[k] = 32'hA500_0000 | 32'(k);
    do_load(70);
    fetch(64'h0);
    fetch(64'h4);
    fetch(64'hF8);
    fetch(64'hFC);
  endtask

  task automatic test_abort();
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      load_we = 1'b1;
      load_data = 32'h5A5A_0000 | 32'(k);
      cyc();
    end
    load_we = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (load_busy !== 1'b1 || fetch_ready !== 1'b0 || load_count !== 7'd0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b ready=%b count=%0d, want 1 0 0", load_busy, fetch_ready, load_count);
    end
    wait_clear("abort");
    fetch(64'h0);
    fetch(64'h4);
    fetch(64'h10);
    fetch(64'hFC);
  endtask

  task automatic test_mixed();
    load_buf[0] = 32'h1111_1111;
    load_buf[1] = 32'h2222_2222;
    do_load(2);
    fetch_req = 1'b1;
    fetch_addr = 64'h0;
    load_start = 1'b1;
    exp_q.push_back(expect_fetch(64'h0));
    cyc();
    fetch_req = 1'b0;
    load_start = 1'b0;
    checks++;
    if (load_busy !== 1'b1 || fetch_ready !== 1'b0) begin
      errors++;
      $display("FAIL mixed_enter: busy=%b ready=%b, want 1 0", load_busy, fetch_ready);
    end
    fetch_req = 1'b1;
    fetch_addr = 64'h4;
    load_we = 1'b1;
    load_data = 32'h3333_3333;
    model[0] = 32'h3333_3333;
    cyc();
    fetch_req = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_in_load: valid=%b, want 0", fetch_valid);
    end
    load_data = 32'h4444_4444;
    load_last = 1'b1;
    model[1] = 32'h4444_4444;
    cyc();
    load_we = 1'b0;
    load_last = 1'b0;
    checks++;
    if (load_count !== 7'd2 || fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL mixed_exit: count=%0d ready=%b, want 2 1", load_count, fetch_ready);
    end
    fetch(64'h0);
    fetch(64'h4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_fault();
    test_back_to_back();
    test_overflow();
    test_abort();
    test_mixed();
    cyc();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_fetches: %0d expected results never returned, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_sync.md
Name: imem_sync

Overview:
Parametrised, clocked successor to the combinational instruction ROM. It holds 2^AW words of N bits in a RAM and serves instruction fetches from a byte-addressed PC with a registered read of 1-cycle latency. Misaligned and out-of-range fetches are flagged as faults. A program-load port writes contents at runtime through an auto-incrementing pointer. After reset, a clear sequence zeroes all words.

Parameters:
N, 32, instruction word width in bits
AW, 6, word-address bits; depth = 2^AW words
PCW, 64, width of the byte-address (PC) input

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
fetch_req  input  1  fetch request, sampled on rising edge
fetch_addr  input  PCW  byte address of instruction
fetch_ready  output  1  high when fetches are accepted (state RUN)
fetch_valid  output  1  fetch_data/fetch_fault valid this cycle
fetch_data  output  N  fetched instruction word
fetch_fault  output  1  accepted fetch was misaligned or out of range
load_start  input  1  begin program load (honoured only in RUN)
load_we  input  1  write load_data at the load pointer
load_data  input  N  word to load
load_last  input  1  qualifies the final load_we beat
load_busy  output  1  high in CLEAR or LOAD
load_count  output  AW+1  words written by the current or last load, saturating at 2^AW

Behaviour:
- Reset is synchronous and active-high on clk. State goes to CLEAR and the pointer ptr to 0.
- Output values under reset: fetch_valid=0, fetch_data=0, fetch_fault=0, fetch_ready=0, load_busy=1, load_count=0.
- State CLEAR:
  - Each cycle writes 0 to mem[ptr] and increments ptr.
  - After the write to index 2^AW-1, the next state is RUN.
  - CLEAR lasts exactly 2^AW cycles after reset deasserts.
  - All other inputs are ignored.
- State RUN:
  - fetch_ready=1, load_busy=0.
  - On load_start=1, the next state is LOAD, with ptr=0 and load_count=0.
- State LOAD:
  - On each cycle with load_we=1 and ptr<2^AW: mem[ptr]<=load_data, ptr++, load_count++.
  - Writes with ptr=2^AW are dropped and load_count holds at 2^AW.
  - On load_we=1 with load_last=1, the beat is written (if in range) and the next state is RUN.
  - load_last without load_we has no effect.
  - Words not written keep their prior contents.
- Fetch decode:
  - Word index = fetch_addr[AW+1:2].
  - fault = (fetch_addr[1:0]!=0) or (fetch_addr[PCW-1:AW+2]!=0).
- Fetch timing:
  - An accepted fetch is fetch_req=1 while fetch_ready=1.
  - One cycle after acceptance: fetch_valid=1, fetch_data=mem[index] (0 if fault), fetch_fault=fault.
  - In all other cycles: fetch_valid=0, fetch_fault=0, and fetch_data holds its last value.
  - A fetch_req while not ready is silently dropped; there is no queuing.
- Simultaneous fetch_req and load_start in RUN: the fetch is accepted and returns pre-load contents next cycle; the state enters LOAD.
- load_start in CLEAR or LOAD is ignored. load_we in RUN or CLEAR is ignored.
- There are no read/write hazards, since fetch and load are mutually exclusive by state.
- Reset mid-LOAD or mid-CLEAR aborts immediately. The block restarts CLEAR and the memory is fully zeroed again.
- load_count retains its final value in RUN until the next load_start.
- Implementation: memory is a register array, one write port and one synchronous read port.

Test Plan:
- Reset 1 cycle, then release. Required: load_busy=1 and fetch_ready=0 for exactly 64 cycles, then fetch_ready=1. A fetch of addr 0x0 then returns data 0x00000000 with valid=1 and fault=0.
- Load 3 words 0xf8000000, 0xf8008001, 0xd61f0300 (last on the third). Required: load_count=3, back in RUN. Then:
  - fetch 0x8 → 0xd61f0300 one cycle later;
  - fetch 0xC → 0x00000000.
- Fault fetches:
  - fetch addr 0x6 → valid=1, fault=1, data=0;
  - fetch 0x100 → fault=1;
  - fetch 0xFC → fault=0, data=mem[63].
- Overflow and abort:
  - Load 70 beats, last on the 70th. Required: load_count=64, mem[0..63] hold the first 64 words, beats 65–70 dropped.
  - Separately, assert reset after 5 beats of a load. Required: CLEAR restarts and afterwards all words read 0.
- Mixed requests:
  - fetch_req with load_start in the same RUN cycle → fetch returns old contents, load_busy=1 next cycle.
  - fetch_req during LOAD → no fetch_valid.
- Back-to-back fetches of 0x0, 0x4, 0x8 on consecutive cycles → three consecutive valid cycles with the matching words.
